// File: rtl/l1_dcache_pkg.sv
// l1_dcache_pkg: FSM states, width helpers, line type and byte-merge helper for l1_dcache_wb
package l1_dcache_pkg;
    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
    localparam int DEF_LINE_WORDS = 8;
    typedef logic [32*DEF_LINE_WORDS-1:0] line_t;
    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction
    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction
    function automatic int tag_w(input int num_sets, input int line_words);
        return 32 - off_w(line_words) - idx_w(num_sets);
    endfunction
    function automatic int line_bits(input int line_words);
        return 32 * line_words;
    endfunction
    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/dcache_lru.sv
// dcache_lru: victim choice and age update for one set
// Ports: valid/age_in describe the indexed set, acc_way is the way being touched;
// victim is the lowest invalid way else the oldest, age_out is the set's ages after touching acc_way.
module dcache_lru #(
    parameter int  NUM_WAYS = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0]       valid,
    input  logic [NUM_WAYS*WAY_W-1:0] age_in,
    input  logic [WAY_W-1:0]          acc_way,
    output logic [WAY_W-1:0]          victim,
    output logic [NUM_WAYS*WAY_W-1:0] age_out
);
    logic [WAY_W-1:0] max_age, acc_age;
    always_comb begin
        victim  = '0;
        max_age = '0;
        acc_age = age_in[acc_way*WAY_W +: WAY_W];
        age_out = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (age_in[w*WAY_W +: WAY_W] >= max_age) begin
                max_age = age_in[w*WAY_W +: WAY_W];
                victim  = WAY_W'(w);
            end
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!valid[w]) victim = WAY_W'(w);
        // move-to-front: only ways more recent than the touched one age by one
        for (int w = 0; w < NUM_WAYS; w++)
            age_out[w*WAY_W +: WAY_W] = (WAY_W'(w) == acc_way) ? '0 :
                (age_in[w*WAY_W +: WAY_W] < acc_age) ? age_in[w*WAY_W +: WAY_W] + 1'b1 :
                age_in[w*WAY_W +: WAY_W];
    end
endmodule

// File: rtl/l1_dcache_wb.sv
// l1_dcache_wb: write-back, write-allocate set-associative L1 data cache, one request outstanding
// Ports: clk, reset (sync, active-high); CPU side req_valid/req_ready/req_we/req_addr/req_wdata/req_wstrb
// with a one-cycle resp_valid/resp_rdata pulse; memory side mem_req_* (we=1 line writeback, we=0 refill)
// and mem_resp_valid/mem_resp_rdata (refill line, word 0 in LSBs).
// Macro L1_DCACHE_PERF_CNT_EN adds saturating 32-bit hit_cnt, miss_cnt and wb_cnt outputs.
module l1_dcache_wb
    import l1_dcache_pkg::*;
#(
    parameter int  NUM_SETS   = 128,
    parameter int  NUM_WAYS   = 4,
    parameter int  LINE_WORDS = 8,
    localparam int OFF_W      = off_w(LINE_WORDS),
    localparam int IDX_W      = idx_w(NUM_SETS),
    localparam int TAG_W      = tag_w(NUM_SETS, LINE_WORDS),
    localparam int LINE_BITS  = line_bits(LINE_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_wstrb,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [31:0]          mem_req_addr,
    output logic [LINE_BITS-1:0] mem_req_wdata,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_rdata
`ifdef L1_DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt,
    output logic [31:0]          wb_cnt
`endif
);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int WOFF_W = $clog2(LINE_WORDS);

    state_t                    state;
    logic [31:0]               addr_r, wdata_r;
    logic                      we_r, sent, hit, unused_ok;
    logic [3:0]                wstrb_r, fill_strb;
    logic [WAY_W-1:0]          vic_r, hit_way, victim, acc_way;
    logic [NUM_WAYS-1:0]       valid [NUM_SETS];
    logic [NUM_WAYS-1:0]       dirty [NUM_SETS];
    logic [TAG_W-1:0]          tag_arr [NUM_SETS][NUM_WAYS];
    logic [LINE_BITS-1:0]      data_arr [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]          age [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS*WAY_W-1:0] age_set, age_new;
    logic [LINE_BITS-1:0]      fill_line;
    logic [31:0]               rd_word, hit_word;
    logic [TAG_W-1:0]          tag;
    logic [IDX_W-1:0]          idx;
    logic [WOFF_W-1:0]         woff;

    assign tag       = addr_r[31 -: TAG_W];
    assign idx       = addr_r[OFF_W +: IDX_W];
    assign woff      = addr_r[2 +: WOFF_W];
    assign unused_ok = &{1'b0, req_addr[1:0], addr_r[1:0]};
    // LOOKUP touches the hit way; every later state works on the registered victim
    assign acc_way   = (state == LOOKUP) ? hit_way : vic_r;
    assign rd_word   = data_arr[idx][acc_way][32*woff +: 32];
    assign hit_word  = merge_word(rd_word, wdata_r, wstrb_r);
    assign fill_strb = we_r ? wstrb_r : 4'b0;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        age_set   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            age_set[w*WAY_W +: WAY_W] = age[idx][w];
            if (valid[idx][w] && tag_arr[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        fill_line = mem_resp_rdata;
        fill_line[32*woff +: 32] = merge_word(mem_resp_rdata[32*woff +: 32], wdata_r, fill_strb);
    end

    dcache_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
        .valid   (valid[idx]),
        .age_in  (age_set),
        .acc_way (acc_way),
        .victim  (victim),
        .age_out (age_new)
    );

    assign req_ready     = state == IDLE;
    assign resp_valid    = (state == LOOKUP && hit) || state == RESPOND;
    assign resp_rdata    = (resp_valid && !we_r) ? rd_word : '0;
    assign mem_req_valid = state == WRITEBACK || (state == REFILL && !sent);
    assign mem_req_we    = state == WRITEBACK;
    assign mem_req_addr  = {((state == WRITEBACK) ? tag_arr[idx][vic_r] : tag), idx, {OFF_W{1'b0}}};
    assign mem_req_wdata = data_arr[idx][vic_r];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sent    <= 1'b0;
            vic_r   <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            we_r    <= 1'b0;
            wstrb_r <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age[s][w] <= WAY_W'(w);
            end
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_r  <= {req_addr[31:2], 2'b00};
                    we_r    <= req_we;
                    wdata_r <= req_wdata;
                    wstrb_r <= req_wstrb;
                    state   <= LOOKUP;
                end
                LOOKUP: if (hit) begin
                    for (int w = 0; w < NUM_WAYS; w++) age[idx][w] <= age_new[w*WAY_W +: WAY_W];
                    if (we_r && |wstrb_r) begin
                        data_arr[idx][hit_way][32*woff +: 32] <= hit_word;
                        dirty[idx][hit_way] <= 1'b1;
                    end
                    state <= IDLE;
                end else begin
                    vic_r <= victim;
                    sent  <= 1'b0;
                    state <= (valid[idx][victim] && dirty[idx][victim]) ? WRITEBACK : REFILL;
                end
                WRITEBACK: if (mem_req_ready) state <= REFILL;
                REFILL: if (!sent) sent <= mem_req_ready;
                else if (mem_resp_valid) begin
                    data_arr[idx][vic_r] <= fill_line;
                    tag_arr[idx][vic_r]  <= tag;
                    valid[idx][vic_r]    <= 1'b1;
                    dirty[idx][vic_r]    <= |fill_strb;
                    for (int w = 0; w < NUM_WAYS; w++) age[idx][w] <= age_new[w*WAY_W +: WAY_W];
                    state <= RESPOND;
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L1_DCACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (state == LOOKUP && hit && ~&hit_cnt) hit_cnt <= hit_cnt + 1'b1;
            if (state == LOOKUP && !hit && ~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
            if (state == WRITEBACK && mem_req_ready && ~&wb_cnt) wb_cnt <= wb_cnt + 1'b1;
        end
    end
`endif
endmodule
